// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: fully registered valid/ready pipeline stage with a one-entry
// skid buffer. Both in_ready and out_valid/out_data come straight from flops,
// so the stage breaks every combinational path between upstream and
// downstream while still sustaining one transfer per cycle.
//
// Optional feature: define PIPE_REG_SKID_PERF_EN to add the 32-bit saturating
// stall_count output (cycles with out_valid=1 and out_ready=0).
module pipe_reg_skid #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_REG_SKID_PERF_EN
    output logic [WIDTH-1:0] out_data,
    output logic [31:0]      stall_count
`else
    output logic [WIDTH-1:0] out_data
`endif
);

    // Occupancy encoded as {skid_vld, main_vld}; 2'b10 can never be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    logic [WIDTH-1:0] main_data_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             main_vld_p1;
    logic             skid_vld_p1;
    logic             in_ready_p1;
    logic             in_fire;
    logic             out_fire;
    state_t           state;

    assign state    = state_t'({skid_vld_p1, main_vld_p1});
    assign in_fire  = in_valid && in_ready_p1;
    assign out_fire = main_vld_p1 && out_ready;

    // ---- stage p1 outputs: everything downstream sees is a flop ----
    assign in_ready  = in_ready_p1;
    assign out_valid = main_vld_p1;
    assign out_data  = main_data_p1;

    // Handshake state machine: main register feeds the output, skid register
    // catches the one beat accepted while downstream was stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_p1  <= 1'b0;
            skid_vld_p1  <= 1'b0;
            in_ready_p1  <= 1'b1;
            main_data_p1 <= RESET_VAL;
            skid_data_p1 <= RESET_VAL;
        end else if (flush) begin
            // Drop everything held and any beat offered this cycle; the data
            // registers keep their contents, only the valid bits clear.
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            in_ready_p1 <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_p1 <= in_data;
                        main_vld_p1  <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_fire && in_fire) begin
                        main_data_p1 <= in_data;
                    end else if (out_fire) begin
                        main_vld_p1 <= 1'b0;
                    end else if (in_fire) begin
                        // Downstream stalled while we had already promised
                        // ready: park the beat and deassert ready.
                        skid_data_p1 <= in_data;
                        skid_vld_p1  <= 1'b1;
                        in_ready_p1  <= 1'b0;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_data_p1 <= skid_data_p1;
                        skid_vld_p1  <= 1'b0;
                        in_ready_p1  <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding; fall back to a clean EMPTY.
                    main_vld_p1 <= 1'b0;
                    skid_vld_p1 <= 1'b0;
                    in_ready_p1 <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_REG_SKID_PERF_EN
    logic [31:0] stall_cnt_p1;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end
        return v + 32'd1;
    endfunction

    assign stall_count = stall_cnt_p1;

    // Count downstream back-pressure cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_p1 <= 32'd0;
        end else if (main_vld_p1 && !out_ready) begin
            stall_cnt_p1 <= sat_inc32(stall_cnt_p1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Testbench for pipe_reg_skid: directed vector table on a 32-bit instance
// (RESET_VAL=DEADBEEF) plus randomized traffic on an 8-bit instance checked
// against a two-entry FIFO reference model.
module tb_pipe_reg_skid;

    localparam int AW = 32;
    localparam int BW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic          a_in_ready, a_out_valid;
    logic [AW-1:0] a_in_data = '0;
    logic [AW-1:0] a_out_data;

    logic          b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic          b_in_ready, b_out_valid;
    logic [BW-1:0] b_in_data = '0;
    logic [BW-1:0] b_out_data;

`ifdef PIPE_REG_SKID_PERF_EN
    logic [31:0] a_stall, b_stall;
`endif

    pipe_reg_skid #(.WIDTH(AW), .RESET_VAL(32'hDEAD_BEEF)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef PIPE_REG_SKID_PERF_EN
        .out_data(a_out_data), .stall_count(a_stall)
`else
        .out_data(a_out_data)
`endif
    );

    pipe_reg_skid #(.WIDTH(BW), .RESET_VAL(8'h5A)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef PIPE_REG_SKID_PERF_EN
        .out_data(b_out_data), .stall_count(b_stall)
`else
        .out_data(b_out_data)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic        cd;
        logic [31:0] eod;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string n, input logic rst, input logic fl,
                                input logic iv, input logic [31:0] d, input logic ordy,
                                input logic eov, input logic eir, input logic cd,
                                input logic [31:0] eod);
        vec_t v;
        v.name = n; v.rst = rst; v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.eov = eov; v.eir = eir; v.cd = cd; v.eod = eod;
        tbl.push_back(v);
    endfunction

    // One clock on instance A: drive at negedge, sample 1 time unit after posedge.
    task automatic a_cycle(input logic rst, input logic fl, input logic iv,
                           input logic [31:0] d, input logic ordy);
        @(negedge clk);
        a_rst = rst; a_flush = fl; a_in_valid = iv; a_in_data = d; a_out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    logic [BW-1:0] q[$];
    logic [BW-1:0] acc[$];
    logic [BW-1:0] obs[$];
    logic [BW-1:0] prev_od;
    logic          prev_stall;
    logic          iv, ordy, in_fire, out_fire;

    initial begin
        // name, rst, flush, in_valid, in_data, out_ready | out_valid, in_ready, check_data, out_data
        add("reset",      1, 0, 0, 32'h0,  0, 0, 1, 1, 32'hDEAD_BEEF);
        add("stream1",    0, 0, 1, 32'h1,  1, 1, 1, 1, 32'h1);
        add("stream2",    0, 0, 1, 32'h2,  1, 1, 1, 1, 32'h2);
        add("stream3",    0, 0, 1, 32'h3,  1, 1, 1, 1, 32'h3);
        add("stream4",    0, 0, 1, 32'h4,  1, 1, 1, 1, 32'h4);
        add("drain",      0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        add("skid_fillA", 0, 0, 1, 32'hA,  0, 1, 1, 1, 32'hA);
        add("skid_pushB", 0, 0, 1, 32'hB,  0, 1, 0, 1, 32'hA);
        add("skid_holdC", 0, 0, 1, 32'hC,  0, 1, 0, 1, 32'hA);
        add("skid_outA",  0, 0, 0, 32'h0,  1, 1, 1, 1, 32'hB);
        add("skid_outB",  0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        add("fl_fill5",   0, 0, 1, 32'h5,  0, 1, 1, 1, 32'h5);
        add("fl_skid6",   0, 0, 1, 32'h6,  0, 1, 0, 1, 32'h5);
        add("fl_flush7",  0, 1, 1, 32'h7,  0, 0, 1, 1, 32'h5);
        add("fl_after",   0, 0, 0, 32'h0,  1, 0, 1, 1, 32'h5);
        add("fl_next8",   0, 0, 1, 32'h8,  1, 1, 1, 1, 32'h8);
        add("fl_empty",   0, 0, 0, 32'h0,  1, 0, 1, 0, 32'h0);
        add("fl2_fill9",  0, 0, 1, 32'h9,  0, 1, 1, 1, 32'h9);
        add("fl2_full",   0, 1, 1, 32'h10, 1, 0, 1, 1, 32'h9);
        add("rst_fill11", 0, 0, 1, 32'h11, 0, 1, 1, 1, 32'h11);
        add("rst_skid12", 0, 0, 1, 32'h12, 0, 1, 0, 1, 32'h11);
        add("rst_mid",    1, 1, 1, 32'h13, 1, 0, 1, 1, 32'hDEAD_BEEF);
        add("rst_after",  0, 0, 0, 32'h0,  1, 0, 1, 1, 32'hDEAD_BEEF);

        foreach (tbl[i]) begin
            a_cycle(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("%s.out_valid", tbl[i].name), {31'd0, a_out_valid}, {31'd0, tbl[i].eov});
            chk($sformatf("%s.in_ready", tbl[i].name), {31'd0, a_in_ready}, {31'd0, tbl[i].eir});
            if (tbl[i].cd) begin
                chk($sformatf("%s.out_data", tbl[i].name), a_out_data, tbl[i].eod);
            end
        end

`ifdef PIPE_REG_SKID_PERF_EN
        // Stall counter: 10 stalled cycles, flush with out_ready=1 (an out-fire,
        // not a stall), one idle cycle, then reset.
        chk("stall.start", a_stall, 32'd0);
        a_cycle(0, 0, 1, 32'h20, 0);
        for (int k = 0; k < 10; k++) begin
            a_cycle(0, 0, 0, 32'h0, 0);
        end
        chk("stall.ten", a_stall, 32'd10);
        a_cycle(0, 1, 0, 32'h0, 1);
        chk("stall.flush", a_stall, 32'd10);
        a_cycle(0, 0, 0, 32'h0, 0);
        chk("stall.idle", a_stall, 32'd10);
        a_cycle(1, 0, 0, 32'h0, 0);
        chk("stall.rst", a_stall, 32'd0);
`endif

        // Randomized traffic on instance B against a two-deep FIFO model.
        @(negedge clk);
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("b_reset.out_valid", {31'd0, b_out_valid}, 32'd0);
        chk("b_reset.in_ready", {31'd0, b_in_ready}, 32'd1);
        chk("b_reset.out_data", {24'd0, b_out_data}, 32'h5A);
`ifdef PIPE_REG_SKID_PERF_EN
        chk("b_reset.stall", b_stall, 32'd0);
`endif
        @(negedge clk);
        b_rst = 1'b0;
        prev_stall = 1'b0;
        prev_od = '0;
        for (int c = 0; c < 1006; c++) begin
            if (c > 0) @(negedge clk);
            if (prev_stall) chk("b_stable", {24'd0, b_out_data}, {24'd0, prev_od});
            iv   = (c < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            ordy = (c < 1000) ? ($urandom_range(0, 1) != 0) : 1'b1;
            b_in_valid  = iv;
            b_in_data   = BW'($urandom);
            b_out_ready = ordy;
            in_fire  = iv && (q.size() < 2);
            out_fire = (q.size() > 0) && ordy;
            if (b_out_valid && ordy) obs.push_back(b_out_data);
            if (in_fire) acc.push_back(b_in_data);
            prev_stall = b_out_valid && !ordy;
            prev_od    = b_out_data;
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(b_in_data);
            @(posedge clk);
            #1;
            chk("b_rand.out_valid", {31'd0, b_out_valid}, {31'd0, (q.size() != 0)});
            chk("b_rand.in_ready", {31'd0, b_in_ready}, {31'd0, (q.size() < 2)});
            if (q.size() != 0) chk("b_rand.out_data", {24'd0, b_out_data}, {24'd0, q[0]});
        end
        chk("b_order.count", obs.size(), acc.size());
        for (int k = 0; k < acc.size() && k < obs.size(); k++) begin
            chk($sformatf("b_order[%0d]", k), {24'd0, obs[k]}, {24'd0, acc[k]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (legal range 1..1024).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, giving the WIDTH-bit value loaded into both data registers on reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1, synchronous pipeline flush (discard contents).
REQ-006 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, WIDTH) forming the upstream handshake.
REQ-007 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, WIDTH) forming the downstream handshake.
REQ-008 The block SHALL have port stall_count, output, 32, the downstream-stall cycle count, present only under PIPE_REG_SKID_PERF_EN.

Function
REQ-009 A transfer SHALL occur when valid && ready are both high at posedge clk: in-fire = in_valid && in_ready; out-fire = out_valid && out_ready.
REQ-010 State SHALL be a main register, a skid register and two valid bits, giving three states: EMPTY (neither valid), FULL (main only) and SKID (both valid).
REQ-011 in_ready SHALL be a registered signal equal to NOT skid-valid; it SHALL be high in EMPTY and FULL and low in SKID, with no combinational path from out_ready.
REQ-012 out_valid SHALL equal main-valid and out_data SHALL equal the main register; there is no combinational path from any input to these outputs.
REQ-013 In EMPTY, in-fire SHALL load main from in_data and move to FULL; with no in-fire the block SHALL stay in EMPTY.
REQ-014 In FULL, the block SHALL behave as follows:
- out-fire with in-fire: load main from in_data, stay in FULL.
- out-fire without in-fire: go to EMPTY.
- in-fire without out-fire: load skid from in_data, go to SKID.
- neither: hold.
REQ-015 In SKID, out-fire SHALL move skid into main and go to FULL; otherwise the block SHALL hold.
REQ-016 Latency from in-fire to out_valid SHALL be 1 cycle, and sustained throughput SHALL be 1 transfer per cycle when out_ready is held high.
REQ-017 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-018 Data order SHALL be strictly preserved, with no loss and no duplication, under any valid/ready pattern.
REQ-019 On flush=1 (and rst=0), both valid bits SHALL clear (state EMPTY) and any in-fire that cycle SHALL be discarded.
REQ-020 An out-fire in the flush cycle SHALL count as completed downstream.
REQ-021 Flush SHALL leave the data register contents unchanged.
REQ-022 The cycle after flush, in_ready SHALL be 1 and out_valid SHALL be 0.

Reset
REQ-023 When rst=1 at posedge clk, the block SHALL set out_valid=0, in_ready=1, main=skid=RESET_VAL (so out_data=RESET_VAL) and stall_count=0.
REQ-024 rst SHALL take priority over flush and over all handshakes.
REQ-025 Reset asserted mid-transfer SHALL drop all held data with no partial transfer.

Configuration
REQ-026 When PIPE_REG_SKID_PERF_EN is defined, stall_count SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0.
REQ-027 stall_count SHALL saturate at 32'hFFFF_FFFF, SHALL be cleared only by rst (not by flush), and SHALL add no logic to the data path.
REQ-028 When PIPE_REG_SKID_PERF_EN is undefined, the stall_count port and its counter SHALL be absent, with data-path behaviour otherwise identical.

Verification
REQ-029 The bench SHALL cover reset: rst=1 for 1 cycle with WIDTH=32, RESET_VAL=32'hDEAD_BEEF -> out_valid=0, in_ready=1, out_data=32'hDEAD_BEEF.
REQ-030 The bench SHALL cover streaming: out_ready=1 and in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data shows 1,2,3,4 one cycle later with out_valid=1 throughout and in_ready never low.
REQ-031 The bench SHALL cover skid: with 0xA held in FULL, drive out_ready=0 and push 0xB -> in_ready=0 next cycle; then raise out_ready -> output 0xA, then 0xB, and in_ready returns high after 0xA leaves.
REQ-032 The bench SHALL cover flush in SKID: state SKID holding 0x5,0x6 and flush=1 with in_valid=1 data 0x7 -> next cycle out_valid=0, in_ready=1; 0x7 never appears at the output.
REQ-033 The bench SHALL cover the stall counter: with PIPE_REG_SKID_PERF_EN, out_valid=1 and out_ready=0 for 10 cycles, then flush -> stall_count=10, still 10 after flush, and 0 after rst.
REQ-034 The bench SHALL cover random valid/ready: 1000 random in_valid/out_ready cycles, WIDTH=8 -> output sequence equals the accepted input sequence exactly, and out_data is stable whenever stalled.
